// File: rtl/sram_array_ctrl.sv
// sram_array_ctrl: single-port 6T SRAM array sequencer with registered word-line, bit-line and pulse timing
module sram_array_ctrl #(
  parameter int ROWS = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH = 8,
  parameter int WR_PULSE_CYC = 2,
  parameter int RD_PULSE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [ROWS-1:0]   wl,
  output logic [WIDTH-1:0]  bl1_drv,
  output logic [WIDTH-1:0]  bl2_drv,
  output logic              read_pulse,
  output logic              write_pulse,
  input  logic [WIDTH-1:0]  bl1_sense,
  input  logic [WIDTH-1:0]  bl2_sense
);
  if (WR_PULSE_CYC < 1) begin : g_bad_wr
    $error("WR_PULSE_CYC must be >= 1");
  end
  if (RD_PULSE_CYC < 1) begin : g_bad_rd
    $error("RD_PULSE_CYC must be >= 1");
  end
  if ((2 ** ADDR_W) < ROWS) begin : g_bad_addr
    $error("ADDR_W too narrow for ROWS");
  end
  typedef enum logic [2:0] {IDLE, SETUP, WPULSE, RPULSE, HOLD} state_t;
  localparam int MAXC = WR_PULSE_CYC > RD_PULSE_CYC ? WR_PULSE_CYC : RD_PULSE_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(ROWS);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic we_q, err_q, accept, in_range, wr_last, rd_last;
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < ROWS_L;
  assign wr_last = cnt == CW'(WR_PULSE_CYC - 1);
  assign rd_last = cnt == CW'(RD_PULSE_CYC - 1);
  always_comb begin
    nxt = state == IDLE   ? (accept && in_range ? SETUP : IDLE)
        : state == SETUP  ? (we_q ? WPULSE : RPULSE)
        : state == WPULSE ? (wr_last ? HOLD : WPULSE)
        : state == RPULSE ? (rd_last ? HOLD : RPULSE)
        : IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  // Array-side outputs are registered from next state so the cells never see req_* combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      wl <= '0;
      bl1_drv <= '0;
      bl2_drv <= '0;
      read_pulse <= 1'b0;
      write_pulse <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cnt <= nxt == state ? cnt + 1'b1 : '0;
      write_pulse <= nxt == WPULSE;
      read_pulse <= nxt == RPULSE;
      rsp_valid <= state == HOLD || (accept && !in_range);
      rsp_err <= (state == HOLD && err_q) || (accept && !in_range);
      if (accept && in_range) begin
        we_q <= req_we;
        err_q <= 1'b0;
        wl <= ROWS'(1) << req_addr;
        bl1_drv <= req_we ? req_wdata : '0;
        bl2_drv <= req_we ? ~req_wdata : '0;
      end else if (state == HOLD) begin
        wl <= '0;
        bl1_drv <= '0;
        bl2_drv <= '0;
      end
      if (state == RPULSE && rd_last) begin
        rsp_rdata <= bl1_sense;
        err_q <= |(bl1_sense ~^ bl2_sense);
      end
    end
  end
endmodule

// File: doc/sram_array_ctrl.md
Name: sram_array_ctrl

Overview:
Single-port sequencer for a ROWS x WIDTH array of 6T SRAM cells. It accepts read/write requests over a valid/ready interface and drives the array timing: one-hot word-line decode, differential bit-line drive, and the read_pulse/write_pulse strobes. It also senses the differential read bit-lines. It sits between the core's memory-request logic and the cell array, and guarantees the cell timing contract: cells latch on the falling edge of write_pulse while WL is high, and read data is valid only while read_pulse and WL are both high.

Parameters:
ROWS, 16, number of word lines (rows) in the array
ADDR_W, 4, request address width; must satisfy 2**ADDR_W >= ROWS
WIDTH, 8, cells per row (data width)
WR_PULSE_CYC, 2, clock cycles write_pulse is held high; must be >= 1 (elaboration error otherwise)
RD_PULSE_CYC, 2, clock cycles read_pulse is held high; must be >= 1 (elaboration error otherwise)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  row address
req_wdata  input  WIDTH  write data
rsp_valid  output  1  one-cycle completion strobe
rsp_rdata  output  WIDTH  read data, held stable until the next rsp_valid
rsp_err  output  1  qualified by rsp_valid: address out of range, or read bit-lines not complementary
wl  output  ROWS  one-hot word lines
bl1_drv  output  WIDTH  true bit-line drive (cell BL1in)
bl2_drv  output  WIDTH  complement bit-line drive (cell BL2in)
read_pulse  output  1  array read strobe
write_pulse  output  1  array write strobe
bl1_sense  input  WIDTH  sensed true bit-lines (cell BL1out)
bl2_sense  input  WIDTH  sensed complement bit-lines (cell BL2out)

Behaviour:
- Reset, applied synchronously at the next edge from any state:
  - state = IDLE; wl = 0; bl1_drv = bl2_drv = 0.
  - read_pulse = write_pulse = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; req_ready = 1 once out of reset.
- All array-side outputs are registered, so there are no combinational paths from req_* to wl or the pulses.
- States: IDLE -> SETUP -> (WPULSE | RPULSE) -> HOLD -> IDLE.
- IDLE:
  - req_ready = 1. On req_valid && req_ready, latch we, addr and wdata.
  - If addr >= ROWS: no array activity; rsp_valid = 1 and rsp_err = 1 in the next cycle; stay in IDLE.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - wl[addr] = 1.
  - Write: bl1_drv = wdata, bl2_drv = ~wdata.
  - Read: bl1_drv = bl2_drv = 0.
  - Both pulses low.
- WPULSE: write_pulse = 1 for exactly WR_PULSE_CYC cycles; wl and bit-line drive held.
- RPULSE:
  - read_pulse = 1 for exactly RD_PULSE_CYC cycles; wl held.
  - At the rising edge that ends the final RPULSE cycle, register bl1_sense into rsp_rdata.
  - At that same edge, set the error flag if any bit has bl1_sense == bl2_sense.
- HOLD (1 cycle):
  - Pulses low; wl and bit-line drive still held, so write_pulse falls with WL high and the data stable.
  - Next state IDLE; rsp_valid = 1 in the first IDLE cycle.
- rsp_valid is high for exactly one cycle.
  - On writes, rsp_rdata is unchanged and rsp_err = 0.
  - req_ready is high in the rsp_valid cycle, so back-to-back requests are accepted.
- Latency from the accept edge to rsp_valid: 3 + WR_PULSE_CYC cycles for a write, 3 + RD_PULSE_CYC cycles for a read. With defaults both are 5.
- Invariants that hold every cycle:
  - read_pulse and write_pulse are never high together.
  - At most one wl bit is high.
  - wl is never 0 while either pulse is high.
- Reset during WPULSE: wl and write_pulse drop at the same edge. The cell write outcome is undefined and must not be checked; the controller state is fully reset.
- req_* inputs outside IDLE are ignored; the latched request is not modified mid-operation.

Test Plan:
- Reset, then write addr 3 data 8'hA5 -> wl = 16'h0008 from accept+1 to accept+4; write_pulse high at accept+2 and accept+3; bl1_drv = A5, bl2_drv = 5A; rsp_valid at accept+5 with rsp_err = 0.
- Read addr 3 with the array model returning bl1 = A5, bl2 = 5A -> read_pulse high for 2 cycles; rsp_rdata = A5, rsp_err = 0 at accept+5.
- Read with bl1_sense = FF, bl2_sense = 0F -> rsp_err = 1, rsp_rdata = FF.
- ROWS = 12, request addr 13 -> no wl or pulse activity; rsp_valid = 1 and rsp_err = 1 one cycle after accept.
- req_valid held high for write addr 0, then read addr 0 -> second accept occurs in the cycle of the first rsp_valid; the read returns the written data; the pulse invariants hold throughout.
- Assert reset in the first WPULSE cycle -> all outputs 0 at the next edge, req_ready = 1 afterwards, no rsp_valid.
